ahb_lite_sram_slave: RTL and testbench

//  Parametrised AHB-Lite slave fronting a synchronous on-chip word memory.

---
 rtl/ahb_lite_sram_slave.sv | 146 ++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-Lite slave fronting a synchronous word memory
// Programmable wait states, little-endian byte lanes and a two-cycle ERROR response.
module ahb_lite_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HMASTLOCK,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [63:0] BYTES = 64'(MEM_DEPTH) * 64'(NB);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t                 state;
    logic [3:0]             cnt;
    logic                   pend;
    logic [LB+IW-1:0]       addr_q;
    logic                   write_q;
    logic [2:0]             size_q;
    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    logic                   accept;
    logic                   illegal;
    logic                   commit;
    logic [6:0]             align_mask;
    logic [NB-1:0]          be;
    logic [IW-1:0]          idx_q;
    logic [IW-1:0]          rd_idx;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic                   unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                    input logic [DATA_WIDTH-1:0] wd,
                                                    input logic [NB-1:0] en);
        merge = old;
        for (int i = 0; i < NB; i++)
            if (en[i]) merge[8*i +: 8] = wd[8*i +: 8];
    endfunction

    assign accept     = HSEL & HREADY & HTRANS[1];
    assign align_mask = (7'd1 << HSIZE) - 7'd1;
    assign illegal    = (64'(HADDR) >= BYTES) | (HSIZE > 3'(LB)) | (|(HADDR[6:0] & align_mask));
    assign commit     = (state == S_IDLE) & pend & write_q;
    assign idx_q      = addr_q[LB +: IW];

    always_comb begin
        be = '0;
        for (int i = 0; i < NB; i++)
            be[i] = (i >= int'(addr_q[LB-1:0])) && (i < int'(addr_q[LB-1:0]) + (1 << size_q));
    end

    // With zero wait states the read is sampled on the same edge that commits the
    // previous write, so a hit on the committing word is forwarded.
    always_comb begin
        rd_idx  = (state == S_WAIT) ? idx_q : HADDR[LB +: IW];
        rd_word = mem[rd_idx];
        if (commit && (idx_q == rd_idx))
            rd_word = merge(mem[rd_idx], HWDATA, be);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET && commit)
            mem[idx_q] <= merge(mem[idx_q], HWDATA, be);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pend      <= 1'b0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= S_IDLE;
                        HREADYOUT <= 1'b1;
                        if (!write_q) HRDATA <= rd_word;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    state     <= S_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        addr_q  <= HADDR[LB+IW-1:0];
                        write_q <= HWRITE;
                        size_q  <= HSIZE;
                        if (illegal) begin
                            state     <= S_ERR1;
                            pend      <= 1'b0;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state     <= S_WAIT;
                            cnt       <= 4'(WAIT_STATES - 1);
                            pend      <= 1'b1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b0;
                        end else begin
                            state     <= S_IDLE;
                            pend      <= 1'b1;
                            HREADYOUT <= 1'b1;
                            HRESP     <= 1'b0;
                            if (!HWRITE) HRDATA <= rd_word;
                        end
                    end else begin
                        state     <= S_IDLE;
                        pend      <= 1'b0;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb/tb_ahb_lite_sram_slave.sv - randomized bench for ahb_lite_sram_slave against a byte-array model
// Two instances: zero wait states and two wait states, exercised one at a time.
module tb_ahb_lite_sram_slave;
    localparam int WS1   = 2;
    localparam int BYTES = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel0, hsel1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    wire         rdy0, rdy1, resp0, resp1;
    wire  [31:0] rd0, rd1;

    always #5 clk = ~clk;

    ahb_lite_sram_slave #(.WAIT_STATES(0)) u0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b001), .HPROT(4'b0011), .HMASTLOCK(1'b0),
        .HWDATA(hwdata), .HREADY(rdy0), .HRDATA(rd0), .HREADYOUT(rdy0), .HRESP(resp0));

    ahb_lite_sram_slave #(.WAIT_STATES(WS1)) u1 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b001), .HPROT(4'b0011), .HMASTLOCK(1'b0),
        .HWDATA(hwdata), .HREADY(rdy1), .HRDATA(rd1), .HREADYOUT(rdy1), .HRESP(resp1));

    int total = 0;
    int bad   = 0;

    logic [7:0] mdl   [2][BYTES];
    bit         known [2][BYTES];

    logic [1:0]  b_trans [16];
    logic        b_write [16];
    logic [31:0] b_addr  [16];
    logic [2:0]  b_size  [16];
    logic [31:0] b_wdata [16];
    int          nb = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic cur_rdy(input int d);
        return (d == 0) ? rdy0 : rdy1;
    endfunction
    function automatic logic cur_resp(input int d);
        return (d == 0) ? resp0 : resp1;
    endfunction
    function automatic logic [31:0] cur_rd(input int d);
        return (d == 0) ? rd0 : rd1;
    endfunction

    function automatic bit legal(input logic [31:0] a, input logic [2:0] s);
        return (s <= 3'd2) && (a < BYTES) && ((a % (32'd1 << s)) == 0);
    endfunction

    function automatic bit exp_err(input int p);
        return b_trans[p][1] && !legal(b_addr[p], b_size[p]);
    endfunction

    task automatic add(input logic [1:0] t, input logic w, input logic [31:0] a,
                       input logic [2:0] s, input logic [31:0] dat);
        b_trans[nb] = t; b_write[nb] = w; b_addr[nb] = a; b_size[nb] = s; b_wdata[nb] = dat;
        nb++;
    endtask

    task automatic check_beat(input int d, input int p, input int waits, input bit lowbad);
        logic [31:0] a, exp;
        bit          all_known;
        if (!b_trans[p][1]) begin
            chk("idle_wait", waits, 0);
            chk("idle_resp", {31'd0, cur_resp(d)}, 0);
        end else if (!legal(b_addr[p], b_size[p])) begin
            chk("err_wait", waits, 1);
            chk("err1_resp", {31'd0, lowbad}, 0);
            chk("err2_resp", {31'd0, cur_resp(d)}, 1);
        end else begin
            chk("ok_wait", waits, (d == 0) ? 0 : WS1);
            chk("ok_lowresp", {31'd0, lowbad}, 0);
            chk("ok_resp", {31'd0, cur_resp(d)}, 0);
            a = b_addr[p];
            if (b_write[p]) begin
                for (int k = 0; k < (1 << b_size[p]); k++) begin
                    mdl[d][a + k]   = b_wdata[p][8 * ((a + k) % 4) +: 8];
                    known[d][a + k] = 1'b1;
                end
            end else begin
                a = a & ~32'd3;
                all_known = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    exp[8*k +: 8] = mdl[d][a + k];
                    if (!known[d][a + k]) all_known = 1'b0;
                end
                if (all_known) chk("rdata", cur_rd(d), exp);
            end
        end
    endtask

    // Pipelined master: address phase of beat i overlaps the data phase of beat i-1.
    task automatic go(input int d);
        int waits;
        bit lowbad;
        for (int i = 0; i <= nb; i++) begin
            hsel0 = (d == 0) && (i < nb);
            hsel1 = (d == 1) && (i < nb);
            if (i < nb) begin
                htrans = b_trans[i]; haddr = b_addr[i]; hwrite = b_write[i]; hsize = b_size[i];
            end else begin
                htrans = 2'b00;
            end
            hwdata = (i > 0) ? b_wdata[i-1] : 32'h0;
            waits  = 0;
            lowbad = 1'b0;
            @(negedge clk);
            while (!cur_rdy(d) && waits <= 40) begin
                if (i > 0 && cur_resp(d) !== exp_err(i - 1)) lowbad = 1'b1;
                waits++;
                @(posedge clk); #1;
                @(negedge clk);
            end
            if (i > 0) check_beat(d, i - 1, waits, lowbad);
            @(posedge clk); #1;
        end
        nb = 0;
    endtask

    initial begin
        logic [1:0]  t;
        logic [2:0]  s;
        logic [31:0] a;
        int          r;
        rst = 1'b1; hsel0 = 0; hsel1 = 0; haddr = 0; htrans = 0; hwrite = 0; hsize = 0; hwdata = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_rdy0", {31'd0, rdy0}, 1);  chk("rst_resp0", {31'd0, resp0}, 0);
        chk("rst_rd0", rd0, 0);
        chk("rst_rdy1", {31'd0, rdy1}, 1);  chk("rst_resp1", {31'd0, resp1}, 0);
        chk("rst_rd1", rd1, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // zero-wait instance: word write/read, byte lane, range and alignment errors, BUSY
        add(2'b10, 1, 32'h10, 2, 32'hDEADBEEF); add(2'b10, 0, 32'h10, 2, 0); go(0);
        add(2'b10, 1, 32'h13, 0, 32'hAA000000); add(2'b10, 0, 32'h10, 2, 0); go(0);
        add(2'b10, 1, 32'h0, 2, 32'h01234567); go(0);
        add(2'b10, 1, 32'h1000, 2, 32'hFFFFFFFF); add(2'b10, 0, 32'h0, 2, 0); go(0);
        add(2'b10, 1, 32'h11, 1, 32'h55555555); add(2'b10, 0, 32'h10, 2, 0); go(0);
        add(2'b10, 1, 32'h30, 2, 32'hA0A0A0A0); add(2'b11, 1, 32'h34, 2, 32'hB1B1B1B1);
        add(2'b01, 1, 32'h38, 2, 32'hEEEEEEEE); add(2'b11, 1, 32'h38, 2, 32'hC2C2C2C2);
        add(2'b10, 0, 32'h30, 2, 0); add(2'b10, 0, 32'h34, 2, 0); add(2'b10, 0, 32'h38, 2, 0);
        go(0);

        // two-wait instance: INCR4 write then readback
        for (int k = 0; k < 4; k++) add(k == 0 ? 2'b10 : 2'b11, 1, 32'h20 + 4*k, 2, $urandom);
        go(1);
        for (int k = 0; k < 4; k++) add(k == 0 ? 2'b10 : 2'b11, 0, 32'h20 + 4*k, 2, 0);
        go(1);

        // reset in the second wait cycle of a write drops it
        add(2'b10, 1, 32'h40, 2, 32'h11223344); go(1);
        hsel1 = 1; htrans = 2'b10; haddr = 32'h40; hwrite = 1; hsize = 2;
        @(posedge clk); #1;
        hsel1 = 0; htrans = 2'b00; hwdata = 32'h55667788;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_rdy", {31'd0, rdy1}, 1);
        chk("midrst_resp", {31'd0, resp1}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        add(2'b10, 0, 32'h40, 2, 0); go(1);

        // randomized traffic on both instances over a pre-initialised 64-byte window
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 16; k++) begin
                add(2'b10, 1, 32'(4*k), 2, $urandom);
                if (nb == 4) go(d);
            end
            for (int it = 0; it < 60; it++) begin
                r = $urandom_range(1, 4);
                for (int k = 0; k < r; k++) begin
                    int c;
                    c = $urandom_range(0, 15);
                    t = (c < 2) ? 2'b00 : (c < 4) ? 2'b01 : ((k == 0) ? 2'b10 : 2'b11);
                    s = 3'($urandom_range(0, 2));
                    a = 32'($urandom_range(0, 63)) & ~((32'd1 << s) - 32'd1);
                    if (c == 15) begin
                        case ($urandom_range(0, 2))
                            0: a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
                            1: begin s = 3'd2; a = 32'($urandom_range(0, 15)) * 4 + 1; end
                            default: s = 3'd3;
                        endcase
                    end
                    add(t, 1'($urandom_range(0, 1)), a, s, $urandom);
                end
                go(d);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
